// File: rtl/clb_carry_pkg.sv
// Shared types and helpers for the chunked carry-chain adder/subtractor.
package clb_carry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for NCHUNKS chunks; a single-chunk build still needs one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/carry_chain.sv
// One narrow ripple carry slice fed with propagate/generate terms and a carry-in.
module carry_chain #(
    parameter int INPUTS = 4
) (
    input  logic [INPUTS-1:0] p,
    input  logic [INPUTS-1:0] g,
    input  logic              ci,
    output logic [INPUTS-1:0] s,
    output logic              co
);

    // A block-local ripple variable keeps the chain free of a self-referencing vector.
    always_comb begin : ripple
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < INPUTS; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        co = c;
    end

endmodule

// File: rtl/carry_chain_sequencer.sv
// Wide add/subtract built by stepping one CHUNK-bit carry_chain across NCHUNKS chunks, LSB first.
module carry_chain_sequencer
    import clb_carry_pkg::*;
#(
    parameter int CHUNK   = 4,
    parameter int NCHUNKS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHUNK*NCHUNKS-1:0] a,
    input  logic [CHUNK*NCHUNKS-1:0] b,
    input  logic                     sub,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHUNK*NCHUNKS-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int W  = CHUNK * NCHUNKS;
    localparam int CW = cnt_width(NCHUNKS);

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [31:0]   base;
    logic          accept;
    logic          last;
    logic [CHUNK-1:0] p_chunk;
    logic [CHUNK-1:0] g_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign last      = (cnt == CW'(NCHUNKS - 1));
    assign base      = 32'(cnt) * 32'(CHUNK);

    assign p_chunk = a_q[base +: CHUNK] ^ b_q[base +: CHUNK];
    assign g_chunk = a_q[base +: CHUNK] & b_q[base +: CHUNK];

    carry_chain #(
        .INPUTS(CHUNK)
    ) u_slice (
        .p (p_chunk),
        .g (g_chunk),
        .ci(carry),
        .s (s_chunk),
        .co(co_chunk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted once at acceptance and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum[base +: CHUNK] <= s_chunk;
            carry              <= co_chunk;
            if (last) begin
                cout <= co_chunk;
                ovf  <= (a_q[W-1] == b_q[W-1]) && (s_chunk[CHUNK-1] != a_q[W-1]);
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_carry_chain_sequencer.sv
// Randomized and directed checks of carry_chain_sequencer against a transaction-level arithmetic model.
module tb_carry_chain_sequencer;

    localparam int CHUNK   = 4;
    localparam int NCHUNKS = 4;
    localparam int W       = CHUNK * NCHUNKS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests_run = 0;
    int tests_failed = 0;
    logic check_en = 1'b0;

    carry_chain_sequencer #(
        .CHUNK  (CHUNK),
        .NCHUNKS(NCHUNKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Plain integer arithmetic: what a W-bit adder/subtractor must produce.
    task automatic compute_ref(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rsub,
                               input logic rcin, output logic [W-1:0] rsum, output logic rcout,
                               output logic rovf);
        int ua, ub, sa, sb, ures, sres;
        ua = int'(ra);
        ub = int'(rb);
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        if (rsub) begin
            ures  = ua - ub;
            sres  = sa - sb;
            rcout = (ua >= ub);
        end else begin
            ures  = ua + ub + int'(rcin);
            sres  = sa + sb + int'(rcin);
            rcout = (ures >= (1 << W));
        end
        rsum = ures[W-1:0];
        rovf = (sres > ((1 << (W-1)) - 1)) || (sres < -(1 << (W-1)));
    endtask

    // Transaction model: 0 = idle, 1 = busy for m_left more edges, 2 = result presented.
    int           m_state;
    int           m_left;
    logic [W-1:0] m_sum, p_sum;
    logic         m_cout, m_ovf, p_cout, p_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_left  <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    logic [W-1:0] ts;
                    logic tc, tv;
                    compute_ref(a, b, sub, cin, ts, tc, tv);
                    p_sum   <= ts;
                    p_cout  <= tc;
                    p_ovf   <= tv;
                    m_left  <= NCHUNKS;
                    m_state <= 1;
                end
                1: if (m_left == 1) begin
                    m_sum   <= p_sum;
                    m_cout  <= p_cout;
                    m_ovf   <= p_ovf;
                    m_state <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (out_ready) m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("in_ready", 32'(in_ready), 32'(m_state == 0));
            checkOutput("out_valid", 32'(out_valid), 32'(m_state == 2));
            if (m_state != 1) begin
                checkOutput("sum", 32'(sum), 32'(m_sum));
                checkOutput("cout", 32'(cout), 32'(m_cout));
                checkOutput("ovf", 32'(ovf), 32'(m_ovf));
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsub,
                                 input logic vcin);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        a        = va;
        b        = vb;
        sub      = vsub;
        cin      = vcin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) checkOutput("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("idle_after_release", 32'(in_ready), 32'd1);
    endtask

    task automatic run_directed(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vsub, input logic vcin, input logic [W-1:0] es,
                                input logic ec, input logic eo, input logic do_release);
        int lat;
        applyStimulus(va, vb, vsub, vcin);
        wait_done(lat);
        checkOutput({name, "_latency"}, 32'(lat), 32'(NCHUNKS));
        checkOutput({name, "_sum"}, 32'(sum), 32'(es));
        checkOutput({name, "_cout"}, 32'(cout), 32'(ec));
        checkOutput({name, "_ovf"}, 32'(ovf), 32'(eo));
        if (do_release) release_result();
    endtask

    initial begin
        logic [W-1:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        rst      = 1'b0;
        check_en = 1'b1;

        run_directed("add_ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
        run_directed("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        run_directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        run_directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        held = sum;
        for (int i = 0; i < 5; i++) begin
            a        = 16'hAAAA;
            b        = 16'h5555;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("stall_sum", 32'(sum), 32'(held));
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_result();

        applyStimulus(16'hF0F0, 16'h0F0F, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mid_sum", 32'(sum), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_directed("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 2) == 0);
            a         = W'($urandom);
            b         = W'($urandom);
            sub       = 1'($urandom_range(0, 1));
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NCHUNKS + 4) @(posedge clk);
        #1;
        checkOutput("final_idle", 32'(in_ready), 32'd1);
        check_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
